// File: rtl/coin_pkg.sv
// -----------------------------------------------------------------------------
// coin_pkg
// Shared definitions between the coin acceptor front-end and the vending FSM.
//   coin_t       : 2-bit coin code carried on the FSM coin input
//   COIN_NONE    : no coin this cycle
//   COIN_2       : value-2 coin
//   COIN_3       : value-3 coin
//   buf_state_t  : occupancy of the one-entry coin buffer in the acceptor
// -----------------------------------------------------------------------------
package coin_pkg;

  typedef logic [1:0] coin_t;

  localparam coin_t COIN_NONE = 2'd0;
  localparam coin_t COIN_2    = 2'd2;
  localparam coin_t COIN_3    = 2'd3;

  localparam int DB_CYCLES_DEF = 4;
  localparam int GAP_DEF       = 1;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

  // Map a single-channel event to its coin code (value-3 channel wins the
  // select; callers guarantee exactly one channel is active).
  function automatic coin_t coin_code(input logic is_val3);
    return is_val3 ? COIN_3 : COIN_2;
  endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// -----------------------------------------------------------------------------
// coin_acceptor_if
// Bundles the coin acceptor's sensor inputs and FSM-facing outputs.
//   sens2     : raw value-2 coin sensor (asynchronous, high while coin passes)
//   sens3     : raw value-3 coin sensor (asynchronous)
//   accept_en : 1 = accept coins, 0 = route every coin to the return chute
//   moneda    : coin code towards the vending FSM, one cycle per coin
//   reject    : one-cycle pulse, coin routed to the return chute
//   err       : one-cycle pulse, both channels fired together (jam)
// Modports:
//   slave  : the acceptor itself
//   master : the environment (sensors, FSM side)
// -----------------------------------------------------------------------------
interface coin_acceptor_if;
  import coin_pkg::*;

  logic  sens2;
  logic  sens3;
  logic  accept_en;
  coin_t moneda;
  logic  reject;
  logic  err;

  modport slave (
    input  sens2,
    input  sens3,
    input  accept_en,
    output moneda,
    output reject,
    output err
  );

  modport master (
    output sens2,
    output sens3,
    output accept_en,
    input  moneda,
    input  reject,
    input  err
  );

endinterface

// File: rtl/coin_debounce.sv
// -----------------------------------------------------------------------------
// coin_debounce
// One coin-sensor channel: 2-flop synchronizer followed by a debounce counter.
// The debounced level only follows the synchronized level after DB_CYCLES
// consecutive differing samples; shorter pulses are swallowed. A registered
// one-cycle pulse marks each rising edge of the debounced level.
//   clk   : block clock
//   rst   : asynchronous reset, active-low
//   sens  : raw sensor line, asynchronous to clk
//   rise  : one-cycle pulse in the cycle after the debounced level goes high
// -----------------------------------------------------------------------------
module coin_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sens,
  output logic rise
);

  // The counter only ever needs to reach DB_CYCLES-1: the DB_CYCLES-th
  // differing sample flips the level directly instead of being stored.
  localparam int CW = (DB_CYCLES <= 2) ? 1 : $clog2(DB_CYCLES);

  logic          sync_p0;
  logic          sync_p1;
  logic          level;
  logic [CW-1:0] cnt;

  // synchronizer stages p0 -> p1, then debounce
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      cnt     <= '0;
      rise    <= 1'b0;
    end else begin
      sync_p0 <= sens;
      sync_p1 <= sync_p0;
      rise    <= 1'b0;
      if (sync_p1 != level) begin
        if (cnt == CW'(DB_CYCLES - 1)) begin
          level <= sync_p1;
          cnt   <= '0;
          rise  <= sync_p1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// -----------------------------------------------------------------------------
// coin_acceptor
// Front-end for the vending FSM. Conditions the two raw coin sensors into
// single-cycle coin codes, rejects jams and coins inserted while disabled,
// and spaces consecutive coins by at least GAP idle cycles, holding one coin
// in a buffer so a closely following coin is not lost.
// Parameters:
//   DB_CYCLES : stable synchronized samples needed to accept a level change
//   GAP       : minimum number of idle moneda cycles between two coins
// Ports:
//   clk  : block clock
//   rst  : asynchronous reset, active-low
//   bus  : coin_acceptor_if.slave (sens2, sens3, accept_en in;
//          moneda, reject, err out, all registered)
// -----------------------------------------------------------------------------
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int GAP       = GAP_DEF
) (
  input  logic           clk,
  input  logic           rst,
  coin_acceptor_if.slave bus
);

  localparam int GW = (GAP < 2) ? 1 : $clog2(GAP + 1);

  logic          rise2;
  logic          rise3;

  buf_state_t    buf_state_q;
  buf_state_t    buf_state_d;
  coin_t         buf_code_q;
  coin_t         buf_code_d;
  coin_t         moneda_q;
  coin_t         moneda_d;
  logic          reject_q;
  logic          reject_d;
  logic          err_q;
  logic          err_d;
  logic [GW-1:0] gap_q;
  logic [GW-1:0] gap_d;
  logic [GW-1:0] gap_dec;

  logic          slot_free;
  logic          jam;
  logic          single;
  logic          issued;
  coin_t         new_code;

  coin_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_db2 (
    .clk  (clk),
    .rst  (rst),
    .sens (bus.sens2),
    .rise (rise2)
  );

  coin_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_db3 (
    .clk  (clk),
    .rst  (rst),
    .sens (bus.sens3),
    .rise (rise3)
  );

  // The gap counter ticks down during idle moneda cycles. The slot is judged
  // on the post-tick value so that the current idle cycle already counts,
  // giving pulses exactly GAP+1 edges apart at the closest.
  always_comb begin
    gap_dec = gap_q;
    if ((moneda_q == COIN_NONE) && (gap_q != '0)) begin
      gap_dec = gap_q - GW'(1);
    end
  end

  assign slot_free = (gap_dec == '0);
  assign jam       = rise2 & rise3;
  assign single    = rise2 ^ rise3;
  assign new_code  = coin_code(rise3);

  always_comb begin
    buf_state_d = buf_state_q;
    buf_code_d  = buf_code_q;
    moneda_d    = COIN_NONE;
    reject_d    = 1'b0;
    err_d       = 1'b0;
    gap_d       = gap_dec;
    issued      = 1'b0;

    // Disabling acceptance drops a waiting coin without a reject pulse.
    if (!bus.accept_en) begin
      buf_state_d = BUF_EMPTY;
    end

    // A waiting coin always goes out before any new arrival.
    if ((buf_state_d == BUF_FULL) && slot_free) begin
      moneda_d    = buf_code_q;
      buf_state_d = BUF_EMPTY;
      gap_d       = GW'(GAP);
      issued      = 1'b1;
    end

    if (jam) begin
      err_d    = 1'b1;
      reject_d = 1'b1;
    end else if (single) begin
      if (!bus.accept_en) begin
        reject_d = 1'b1;
      end else if (slot_free && !issued) begin
        moneda_d = new_code;
        gap_d    = GW'(GAP);
      end else if (buf_state_d == BUF_EMPTY) begin
        // Either the gap is still running or the slot was just taken by the
        // buffered coin; in both cases the new coin waits its turn.
        buf_state_d = BUF_FULL;
        buf_code_d  = new_code;
      end else begin
        reject_d = 1'b1;
      end
    end
  end

  // output / state register stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_state_q <= BUF_EMPTY;
      buf_code_q  <= COIN_NONE;
      moneda_q    <= COIN_NONE;
      reject_q    <= 1'b0;
      err_q       <= 1'b0;
      gap_q       <= '0;
    end else begin
      buf_state_q <= buf_state_d;
      buf_code_q  <= buf_code_d;
      moneda_q    <= moneda_d;
      reject_q    <= reject_d;
      err_q       <= err_d;
      gap_q       <= gap_d;
    end
  end

  assign bus.moneda = moneda_q;
  assign bus.reject = reject_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// -----------------------------------------------------------------------------
// tb_coin_acceptor
// Two acceptors share one set of sensor inputs: u_a with GAP=1 and u_b with a
// long gap so the buffer-full case can be reached with real sensor timing.
// A reference model built from sample histories and issue timestamps
// predicts both instances every cycle; a vector table and a few hand-written
// sequences check the named scenarios with fixed expectations.
// -----------------------------------------------------------------------------
module tb_coin_acceptor;
  import coin_pkg::*;

  localparam int DB    = 4;
  localparam int GAP_A = 1;
  localparam int GAP_B = 12;

  logic clk       = 1'b0;
  logic rst       = 1'b0;
  logic sens2     = 1'b0;
  logic sens3     = 1'b0;
  logic accept_en = 1'b1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  coin_acceptor_if if_a();
  coin_acceptor_if if_b();

  assign if_a.sens2     = sens2;
  assign if_a.sens3     = sens3;
  assign if_a.accept_en = accept_en;
  assign if_b.sens2     = sens2;
  assign if_b.sens3     = sens3;
  assign if_b.accept_en = accept_en;

  coin_acceptor #(.DB_CYCLES(DB), .GAP(GAP_A)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  coin_acceptor #(.DB_CYCLES(DB), .GAP(GAP_B)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  task automatic check(input string name, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp_v);
    end
  endtask

  function automatic int outs_a();
    return int'({if_a.moneda, if_a.reject, if_a.err});
  endfunction

  function automatic int outs_b();
    return int'({if_b.moneda, if_b.reject, if_b.err});
  endfunction

  // ---------------- reference model ----------------
  // hist[c][0..DB-1] are the raw samples taken DB+1..2 edges ago; the
  // debounced level flips when all of them disagree with it.
  bit    hist [2][0:DB];
  bit    dbl  [2];
  bit    rise_pend [2];
  int    n_edge;
  int    last_iss [2];
  bit    bufv [2];
  coin_t bufc [2];
  coin_t exp_m [2];
  bit    exp_r [2];
  bit    exp_e [2];

  function automatic int gapv(input int k);
    return (k == 0) ? GAP_A : GAP_B;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int j = 0; j <= DB; j++) hist[c][j] = 1'b0;
      dbl[c]       = 1'b0;
      rise_pend[c] = 1'b0;
      last_iss[c]  = -1000000;
      bufv[c]      = 1'b0;
      bufc[c]      = COIN_NONE;
      exp_m[c]     = COIN_NONE;
      exp_r[c]     = 1'b0;
      exp_e[c]     = 1'b0;
    end
  endtask

  task automatic model_issue(input int k);
    bit e2, e3, acc, free, issued, r, e;
    coin_t m;
    e2 = rise_pend[0];
    e3 = rise_pend[1];
    acc = accept_en;
    m = COIN_NONE; r = 1'b0; e = 1'b0; issued = 1'b0;
    free = (n_edge - last_iss[k]) > gapv(k);
    if (!acc) bufv[k] = 1'b0;
    if (bufv[k] && free) begin
      m = bufc[k]; bufv[k] = 1'b0; last_iss[k] = n_edge; issued = 1'b1;
    end
    if (e2 && e3) begin
      e = 1'b1; r = 1'b1;
    end else if (e2 || e3) begin
      if (!acc) r = 1'b1;
      else if (free && !issued) begin
        m = e3 ? COIN_3 : COIN_2; last_iss[k] = n_edge;
      end else if (!bufv[k]) begin
        bufv[k] = 1'b1; bufc[k] = e3 ? COIN_3 : COIN_2;
      end else r = 1'b1;
    end
    exp_m[k] = m; exp_r[k] = r; exp_e[k] = e;
  endtask

  task automatic model_debounce();
    bit s [2];
    bit diff;
    s[0] = sens2;
    s[1] = sens3;
    for (int c = 0; c < 2; c++) begin
      diff = 1'b1;
      for (int j = 0; j < DB; j++) if (hist[c][j] == dbl[c]) diff = 1'b0;
      rise_pend[c] = diff && !dbl[c];
      if (diff) dbl[c] = !dbl[c];
      for (int j = 0; j < DB; j++) hist[c][j] = hist[c][j+1];
      hist[c][DB] = s[c];
    end
  endtask

  initial begin
    n_edge = 0;
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else begin
        n_edge++;
        model_issue(0);
        model_issue(1);
        model_debounce();
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("model_a", outs_a(), int'({exp_m[0], exp_r[0], exp_e[0]}));
      check("model_b", outs_b(), int'({exp_m[1], exp_r[1], exp_e[1]}));
    end
  end

  // ---------------- directed stimulus ----------------
  typedef struct {
    bit    s2;
    bit    s3;
    int    len;
    bit    acc;
    int    n2;
    int    n3;
    int    nrej;
    int    nerr;
    int    lat;
    string name;
  } vec_t;

  vec_t vt [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int c);
    sens2 = 1'b0; sens3 = 1'b0; accept_en = 1'b1;
    repeat (c) tick();
  endtask

  // sens2 coin, sens3 coin one edge later, optional third sens2 coin while
  // u_b still holds the second, optional accept_en drop while it is held.
  task automatic two_coin_seq(input bit third, input bit drop);
    int ea, eb;
    sens2 = 1'b1;
    for (int i = 0; i <= 25; i++) begin
      tick();
      ea = (i == 6) ? 8 : (i == 8) ? 12 : (third && i == 16) ? 8 : 0;
      eb = (i == 6) ? 8 : (!drop && i == 19) ? 12 : (third && i == 16) ? 2 : 0;
      check(drop ? "drop_a" : "seq_a", outs_a(), ea);
      check(drop ? "drop_b" : "seq_b", outs_b(), eb);
      if (i == 0) sens3 = 1'b1;
      if (i == 4) sens2 = 1'b0;
      if (i == 8) sens3 = 1'b0;
      if (third && i == 9)  sens2 = 1'b1;
      if (third && i == 14) sens2 = 1'b0;
      if (drop && i == 9)  accept_en = 1'b0;
      if (drop && i == 10) accept_en = 1'b1;
    end
  endtask

  initial begin
    int c2, c3, cr, ce, lat;
    int h2c, h3c, hac;

    vt[0] = '{1'b1, 1'b0, 10, 1'b1, 1, 0, 0, 0,  6, "s2_long"};
    vt[1] = '{1'b0, 1'b1,  3, 1'b1, 0, 0, 0, 0, -1, "s3_glitch"};
    vt[2] = '{1'b0, 1'b1,  8, 1'b1, 0, 1, 0, 0,  6, "s3_stable"};
    vt[3] = '{1'b1, 1'b1,  6, 1'b1, 0, 0, 1, 1,  6, "jam"};
    vt[4] = '{1'b0, 1'b1,  8, 1'b0, 0, 0, 1, 0,  6, "s3_disabled"};
    vt[5] = '{1'b1, 1'b0,  4, 1'b1, 1, 0, 0, 0,  6, "s2_min_len"};
    vt[6] = '{1'b1, 1'b0,  3, 1'b1, 0, 0, 0, 0, -1, "s2_short"};

    // reset state
    #2;
    check("reset_a", outs_a(), 0);
    check("reset_b", outs_b(), 0);
    #20;
    @(negedge clk) rst = 1'b1;
    tick();

    for (int v = 0; v < 7; v++) begin
      idle(20);
      c2 = 0; c3 = 0; cr = 0; ce = 0; lat = -1;
      sens2 = vt[v].s2; sens3 = vt[v].s3; accept_en = vt[v].acc;
      for (int i = 0; i < 30; i++) begin
        tick();
        if (if_a.moneda == COIN_2) c2++;
        if (if_a.moneda == COIN_3) c3++;
        if (if_a.reject) cr++;
        if (if_a.err) ce++;
        if (lat < 0 && outs_a() != 0) lat = i;
        if (i == vt[v].len - 1) begin
          sens2 = 1'b0; sens3 = 1'b0;
        end
      end
      accept_en = 1'b1;
      check({vt[v].name, "_n2"},   c2,  vt[v].n2);
      check({vt[v].name, "_n3"},   c3,  vt[v].n3);
      check({vt[v].name, "_nrej"}, cr,  vt[v].nrej);
      check({vt[v].name, "_nerr"}, ce,  vt[v].nerr);
      check({vt[v].name, "_lat"},  lat, vt[v].lat);
    end

    idle(30);
    two_coin_seq(1'b1, 1'b0);
    idle(30);
    two_coin_seq(1'b0, 1'b1);

    // async reset while a coin pulse is on the output
    idle(30);
    sens2 = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      tick();
      if (i == 6) check("pre_rst_pulse", outs_a(), 8);
    end
    #2 rst = 1'b0;
    #1;
    check("rst_now_a", outs_a(), 0);
    check("rst_now_b", outs_b(), 0);
    sens2 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    tick();

    // reset mid-debounce, released with the sensor still high
    idle(30);
    sens2 = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("rst_mid_a", outs_a(), 0);
    check("rst_mid_b", outs_b(), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    for (int j = 0; j <= 15; j++) begin
      tick();
      check("rst_release", outs_a(), (j == 6) ? 8 : 0);
      if (j == 9) sens2 = 1'b0;
    end

    // randomized traffic, checked by the model
    idle(30);
    h2c = 0; h3c = 0; hac = 0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (h2c == 0) begin
        sens2 = 1'($urandom_range(0, 1)); h2c = int'($urandom_range(1, 14));
      end else h2c--;
      if (h3c == 0) begin
        sens3 = 1'($urandom_range(0, 1)); h3c = int'($urandom_range(1, 14));
      end else h3c--;
      if (hac == 0) begin
        accept_en = ($urandom_range(0, 99) < 85);
        hac = int'($urandom_range(1, 20));
      end else hac--;
      if (c == 2000) begin
        #2 rst = 1'b0;
      end
      if (c == 2003) rst = 1'b1;
    end

    idle(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end for the vending FSM: conditions two raw coin-sensor lines (value-2 and value-3 coins) into single-cycle `moneda` codes on the FSM's 2-bit coin input. It synchronizes and debounces each sensor and rejects jams and disabled-state inserts. Back-to-back coins are spaced by a minimum gap, with one coin buffered so a closely following coin is not dropped.

## Interface
- `DB_CYCLES`, 4: consecutive stable synchronized samples required before a sensor level change is accepted (≥2).
- `GAP`, 1: minimum number of all-zero `moneda` cycles between two coin pulses (≥1).
- `clk`  in  1  single clock for the block.
- `rst`  in  1  reset; asynchronous, active-low.
- `sens2`  in  1  raw sensor, value-2 coin, high while the coin passes, asynchronous to `clk`.
- `sens3`  in  1  raw sensor, value-3 coin, same behaviour.
- `accept_en`  in  1  high = coins accepted; low = coins returned.
- `moneda`  out  2  coin code to the FSM: 2'd0 none, 2'd2 value-2 coin, 2'd3 value-3 coin; 2'd1 never driven.
- `reject`  out  1  one-cycle pulse: coin routed to the return chute.
- `err`  out  1  one-cycle pulse: jam (both channels fired in the same cycle).

## Operation
- Each channel: 2-flop synchronizer, then debouncer. A counter runs while the synchronized level differs from the debounced level and clears when they match. When the counter hits `DB_CYCLES`, the debounced level flips and the counter clears. Pulses shorter than `DB_CYCLES` are ignored.
- An event is the rising edge of a debounced level. Falling edges produce nothing.
- Both channels raise an event in the same cycle: `err`=1 and `reject`=1 for one cycle. Neither coin is issued or buffered.
- Single event with `accept_en`=0: `reject` pulse. Not buffered.
- Single event with `accept_en`=1:
  - If the issue slot is free (gap elapsed, buffer empty): issue on `moneda` next cycle.
  - Else, if the buffer is empty: store the event.
  - Else: `reject` pulse.
- Buffer has priority. When the gap elapses, the buffered coin issues first. A new event arriving in that same cycle goes into the freed buffer.
- `accept_en` low flushes the buffer silently; nothing is issued and no `reject` pulse is produced.
- Each issued code lasts exactly one cycle. The gap counter loads `GAP` on issue and counts down while `moneda`=0.
- A sensor held high through reset release is seen as a rising edge and counts as a coin after debounce.

## Timing
- Reset values: `moneda`=0, `reject`=0, `err`=0. Synchronizers, debounced levels, counters and gap counter are all 0; buffer empty.
- Reset is asynchronous. Asserting it mid-debounce or with a coin buffered drops that coin, with no `reject`.
- Let k0 be the first edge sampling a raw line high, with the line held stable. The debounced level rises at edge k0+1+`DB_CYCLES`. The `moneda` pulse, or `reject`/`err`, is registered and asserted from edge k0+2+`DB_CYCLES` for one cycle.
- With defaults, latency is 6 edges from the first sample to the pulse.
- Minimum distance between consecutive `moneda` pulses is `GAP`+1 edges.
- A buffered coin issues on the first edge at which the gap counter is 0.
- `reject` and `err` are never delayed by the gap. They may coincide with a `moneda` pulse.

## Structure
- Shared package `coin_pkg`: coin codes `COIN_NONE`=2'd0, `COIN_2`=2'd2, `COIN_3`=2'd3, plus a `coin_t` typedef. The vending FSM imports the same package.
- Sub-module `coin_debounce` (synchronizer + debounce counter + rise-event output), parameterized by `DB_CYCLES`, instantiated once per channel.
- Top level holds the jam check, accept gating, one-entry buffer, gap counter and output registers.

## Test plan
- Reset with sensors low; `sens2` high for 10 cycles, `accept_en`=1: `moneda`=2'd2 for exactly one cycle, 6 edges after the first high sample; `reject`/`err` stay 0.
- `sens3` glitch high for 3 cycles (`DB_CYCLES`=4): no `moneda`, `reject` or `err`. Then a stable 8-cycle pulse: one `moneda`=2'd3.
- `sens2` and `sens3` rise in the same cycle: `err`=1 and `reject`=1 for one cycle; `moneda` stays 0.
- Debounced rises on `sens2` then `sens3` one cycle apart, with `GAP`=1: `moneda`=2, then 0, then 3. A third coin arriving while the buffer is still full: `reject` pulse only.
- `accept_en`=0 during a `sens3` insert: `reject` pulse, `moneda`=0. Buffer a coin and drop `accept_en`: the coin is never issued.
- Assert `rst` low two cycles after a `sens2` rise: all outputs 0 immediately. Release with `sens2` still high: exactly one `moneda`=2'd2 after `DB_CYCLES`+2 edges.
